// File: rtl/rx_loader.sv
// rx_loader: takes bytes from the UART receiver and writes them into data
// memory in raster order. Column is in mem_address[COL_W-1:0] and row is in
// the bits above it. A load runs from address 0 up to the captured end
// address, then parks in DONE. Bytes that arrive when the block cannot take
// them are dropped and flagged on the sticky overrun output.
//
// Handshake: rx_done is a valid-only strobe with no back-pressure. A byte is
// consumed only when rx_done is high in WAIT_BYTE. In every other state the
// byte is lost. A drop in WRITE or DONE is recorded in overrun. In IDLE the
// byte is ignored silently. mem_wen is a one-cycle write strobe with no
// ready: the memory must accept every write. mem_address and mem_data are
// valid in the same cycle as mem_wen.
module rx_loader #(
    parameter int DATA_W = 8,
    parameter int COL_W  = 9,
    parameter int ROW_W  = 9
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ROW_W+COL_W-1:0]   end_address,
    input  logic                     rx_done,
    input  logic [DATA_W-1:0]        rx_data,
    output logic                     mem_wen,
    output logic [ROW_W+COL_W-1:0]   mem_address,
    output logic [DATA_W-1:0]        mem_data,
    output logic                     busy,
    output logic                     done,
    output logic                     overrun
);

    localparam int ADDR_W = ROW_W + COL_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BYTE = 2'd1,
        WRITE     = 2'd2,
        DONE      = 2'd3
    } state_t;

    // state is kept as a named enum so checkers can bind to it directly
    state_t            state;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] end_reg;

    // Field views of the captured end address
    logic [COL_W-1:0]  end_col;
    logic [ROW_W-1:0]  end_row;
    logic              at_end;
    logic              at_end_col;

    // Decode the end-of-row and end-of-load conditions from the registered counters
    always_comb begin
        end_col    = end_reg[COL_W-1:0];
        end_row    = end_reg[ADDR_W-1:COL_W];
        at_end_col = (col == end_col);
        at_end     = at_end_col && (row == end_row);
    end

    // The address output is the live counter pair. The counters are
    // registers, so the output is registered too. The counters only move at
    // the end of WRITE, so the address holds steady while mem_wen is high.
    assign mem_address = {row, col};

    // Main load FSM. All outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            col      <= '0;
            row      <= '0;
            end_reg  <= '0;
            mem_wen  <= 1'b0;
            mem_data <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            // The write strobe lasts exactly one cycle unless it is re-armed below
            mem_wen <= 1'b0;

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        // If start and a byte arrive together, start wins. The
                        // byte is neither captured nor counted as an overrun.
                        state   <= WAIT_BYTE;
                        col     <= '0;
                        row     <= '0;
                        end_reg <= end_address;
                        overrun <= 1'b0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                    end else if (rx_done && (state == DONE)) begin
                        // A byte after the load has finished has nowhere to go
                        overrun <= 1'b1;
                    end
                end

                WAIT_BYTE: begin
                    if (rx_done) begin
                        mem_data <= rx_data;
                        mem_wen  <= 1'b1;
                        state    <= WRITE;
                    end
                end

                WRITE: begin
                    // The write happens in this cycle. A byte arriving now cannot be
                    // held, because there is only one data register.
                    if (rx_done) begin
                        overrun <= 1'b1;
                    end

                    if (at_end) begin
                        // Hold the final address and report completion
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (at_end_col) begin
                        // End of a row: wrap the column and advance the row. The
                        // row cannot pass end_row, because at_end stops the load first.
                        col   <= '0;
                        row   <= row + 1'b1;
                        state <= WAIT_BYTE;
                    end else begin
                        col   <= col + 1'b1;
                        state <= WAIT_BYTE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_loader.sv
// Directed bench for rx_loader. A table of loads is applied in a loop, and
// hand-written sequences cover the multi-cycle corner cases. Every memory
// write is checked against an expected queue that an independent raster
// model fills.
module tb_rx_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [17:0] end_address;
    logic        rx_done;
    logic [7:0]  rx_data;
    logic        mem_wen;
    logic [17:0] mem_address;
    logic [7:0]  mem_data;
    logic        busy;
    logic        done;
    logic        overrun;

    int checks   = 0;
    int failures = 0;

    // Expected writes, packed as {address, data}
    logic [25:0] exp_q[$];
    logic [25:0] mon_e;

    rx_loader #(
        .DATA_W(8),
        .COL_W (9),
        .ROW_W (9)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .end_address(end_address),
        .rx_done    (rx_done),
        .rx_data    (rx_data),
        .mem_wen    (mem_wen),
        .mem_address(mem_address),
        .mem_data   (mem_data),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every write strobe seen on the falling edge must match the queue head
    always @(negedge clk) begin
        if (rst_n === 1'b1 && mem_wen === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=0x%0h required=no_write", {mem_address, mem_data});
            end else begin
                mon_e = exp_q.pop_front();
                check("write_addr_data", {6'b0, mem_address, mem_data}, {6'b0, mon_e});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start, then scramble end_address to show that later changes are ignored
    task automatic do_start(input logic [17:0] ea);
        end_address = ea;
        start       = 1'b1;
        tick();
        start       = 1'b0;
        end_address = ~ea;
    endtask

    // One byte, with the minimum legal spacing of two cycles
    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        tick();
    endtask

    // Independent raster model: rows outer, columns inner, at most n entries
    task automatic push_exp(input logic [17:0] ea, input logic [7:0] b0, input int n);
        int k;
        logic [7:0] b;
        k = 0;
        for (int r = 0; r <= int'(ea[17:9]); r++) begin
            for (int c = 0; c <= int'(ea[8:0]); c++) begin
                if (k < n) begin
                    b = b0 + k[7:0];
                    exp_q.push_back({r[8:0], c[8:0], b});
                    k++;
                end
            end
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [17:0] end_addr;
        int          n_bytes;
        logic [7:0]  first;
    } vec_t;

    vec_t vecs[5];

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] b;

        rst_n       = 1'b0;
        start       = 1'b0;
        rx_done     = 1'b0;
        rx_data     = 8'h00;
        end_address = 18'h0;

        // 2x3 load, single location, a 3x1 column, a 1x4 row, and 2 full-width rows
        vecs[0] = '{18'h00202, 6,    8'h10};
        vecs[1] = '{18'h00000, 1,    8'hA5};
        vecs[2] = '{18'h00400, 3,    8'h40};
        vecs[3] = '{18'h00003, 4,    8'h60};
        vecs[4] = '{18'h003FF, 1024, 8'h00};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {2'b0, mem_wen, mem_address, mem_data, busy, done, overrun}, 32'h0);
        rst_n = 1'b1;
        tick();

        // A byte in IDLE is ignored and does not set overrun
        send_byte(8'h77);
        check("idle_rx_overrun", {31'b0, overrun}, 32'd0);
        check("idle_rx_busy", {31'b0, busy}, 32'd0);

        // Table-driven loads
        for (int i = 0; i < 5; i++) begin
            do_start(vecs[i].end_addr);
            check("start_busy", {31'b0, busy}, 32'd1);
            check("start_done", {31'b0, done}, 32'd0);
            push_exp(vecs[i].end_addr, vecs[i].first, vecs[i].n_bytes);
            for (int k = 0; k < vecs[i].n_bytes; k++) begin
                if (k == vecs[i].n_bytes - 1) begin
                    check("done_before_last", {31'b0, done}, 32'd0);
                end
                b = vecs[i].first + k[7:0];
                send_byte(b);
            end
            check("load_done", {31'b0, done}, 32'd1);
            check("load_busy", {31'b0, busy}, 32'd0);
            check("load_overrun", {31'b0, overrun}, 32'd0);
            check("load_final_addr", {14'b0, mem_address}, {14'b0, vecs[i].end_addr});
            check("load_queue_empty", exp_q.size(), 32'd0);
        end

        // Single location, then an extra byte in DONE: it is dropped with overrun
        do_start(18'h0);
        push_exp(18'h0, 8'hA5, 1);
        send_byte(8'hA5);
        check("single_done", {31'b0, done}, 32'd1);
        send_byte(8'h5A);
        check("done_rx_overrun", {31'b0, overrun}, 32'd1);
        check("done_data_hold", {24'b0, mem_data}, 32'hA5);

        // start and rx_done together in DONE: restart, no capture, overrun cleared
        end_address = 18'h00001;
        rx_data     = 8'hEE;
        start       = 1'b1;
        rx_done     = 1'b1;
        tick();
        start       = 1'b0;
        rx_done     = 1'b0;
        check("simul_overrun", {31'b0, overrun}, 32'd0);
        check("simul_done", {31'b0, done}, 32'd0);
        check("simul_busy", {31'b0, busy}, 32'd1);
        check("simul_no_wen", {31'b0, mem_wen}, 32'd0);

        // start in the middle of a load is ignored
        push_exp(18'h00001, 8'h30, 2);
        send_byte(8'h30);
        do_start(18'h0);
        check("midstart_busy", {31'b0, busy}, 32'd1);
        check("midstart_addr", {14'b0, mem_address}, 32'h1);
        send_byte(8'h31);
        check("midstart_done", {31'b0, done}, 32'd1);
        check("midstart_queue", exp_q.size(), 32'd0);

        // Back-to-back pulses at N and N+1: one write, second byte dropped
        do_start(18'h00003);
        exp_q.push_back({18'h0, 8'h50});
        rx_data = 8'h50;
        rx_done = 1'b1;
        tick();
        check("b2b_wen", {31'b0, mem_wen}, 32'd1);
        check("b2b_addr", {14'b0, mem_address}, 32'h0);
        rx_data = 8'h51;
        tick();
        rx_done = 1'b0;
        check("b2b_overrun", {31'b0, overrun}, 32'd1);
        check("b2b_wen_low", {31'b0, mem_wen}, 32'd0);
        check("b2b_next_addr", {14'b0, mem_address}, 32'h1);
        exp_q.push_back({18'h1, 8'h52});
        exp_q.push_back({18'h2, 8'h53});
        exp_q.push_back({18'h3, 8'h54});
        send_byte(8'h52);
        send_byte(8'h53);
        send_byte(8'h54);
        check("b2b_done", {31'b0, done}, 32'd1);

        // Pulses at N and N+2: two writes, no overrun
        do_start(18'h00001);
        push_exp(18'h00001, 8'h60, 2);
        send_byte(8'h60);
        send_byte(8'h61);
        check("spaced_overrun", {31'b0, overrun}, 32'd0);
        check("spaced_done", {31'b0, done}, 32'd1);

        // Maximum range: check the column wrap 0x001FF -> 0x00200, then abandon with reset
        do_start(18'h3FFFF);
        push_exp(18'h3FFFF, 8'h00, 514);
        for (int k = 0; k < 514; k++) begin
            b = k[7:0];
            send_byte(b);
        end
        check("max_addr_after_wrap", {14'b0, mem_address}, 32'h202);
        check("max_busy", {31'b0, busy}, 32'd1);
        check("max_done", {31'b0, done}, 32'd0);
        check("max_queue", exp_q.size(), 32'd0);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();

        // Reset mid-load at address 5 while mem_wen is high
        do_start(18'h0000A);
        push_exp(18'h0000A, 8'h10, 6);
        for (int k = 0; k < 5; k++) begin
            b = 8'h10 + k[7:0];
            send_byte(b);
        end
        rx_data = 8'h15;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        check("prereset_wen", {31'b0, mem_wen}, 32'd1);
        check("prereset_addr", {14'b0, mem_address}, 32'h5);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {2'b0, mem_wen, mem_address, mem_data, busy, done, overrun}, 32'h0);
        check("reset_queue", exp_q.size(), 32'd0);
        #1;
        rst_n = 1'b1;
        tick();

        // After reset, bytes produce no writes until start
        send_byte(8'h81);
        send_byte(8'h82);
        send_byte(8'h83);
        check("post_reset_busy", {31'b0, busy}, 32'd0);
        check("post_reset_overrun", {31'b0, overrun}, 32'd0);
        check("post_reset_done", {31'b0, done}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Time limit so the run always ends
    initial begin
        #5000000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rx_loader.md
# rx_loader

Receive-side counterpart to the transmit path. Takes bytes from the UART receiver and writes them into data memory at raster-ordered addresses: column in `mem_address[8:0]`, row in `mem_address[17:9]`. It stops once the captured end address has been written, then ignores further bytes and flags them. It sits between the UART Rx block and the memory write port, mirroring the retriever/Tx path that reads the same address space out.

## Interface
Parameters:
- `DATA_W`, 8, byte width from the UART receiver.
- `COL_W`, 9, column field width (low address bits).
- `ROW_W`, 9, row field width (high address bits); address width is `ROW_W+COL_W` = 18.

Ports:
- `clk`  in  1  single system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begins a load; honoured only in IDLE or DONE.
- `end_address`  in  18  last address to write, as {row, col}; sampled on accepted `start`.
- `rx_done`  in  1  one-cycle pulse from the UART Rx: `rx_data` is valid this cycle.
- `rx_data`  in  DATA_W  received byte.
- `mem_wen`  out  1  memory write enable, one cycle per accepted byte.
- `mem_address`  out  18  write address {row, col}.
- `mem_data`  out  DATA_W  write data, registered copy of `rx_data`.
- `busy`  out  1  high in WAIT_BYTE and WRITE.
- `done`  out  1  high in DONE; held until the next accepted `start`.
- `overrun`  out  1  sticky; set when a byte is dropped; cleared by accepted `start` or reset.

## Operation
States: IDLE, WAIT_BYTE, WRITE, DONE. All outputs are registered.

IDLE
- Outputs are 0; `rx_done` is ignored and does not set `overrun`.
- `start` → WAIT_BYTE, address ← 0, `end_address` latched into `end_reg`, `overrun` ← 0.

WAIT_BYTE
- `rx_done` → `mem_data` ← `rx_data`, go to WRITE.

WRITE
- Lasts exactly one cycle; `mem_wen` = 1 with the current address.
- If address == `end_reg`: go to DONE, address held.
- Otherwise, raster increment:
  - col ≠ `end_reg[8:0]`: col + 1.
  - col == `end_reg[8:0]`: col ← 0, row + 1.
  - Go to WAIT_BYTE.
- `rx_done` arriving in WRITE sets `overrun`; the byte is dropped.

DONE
- `done` = 1.
- `rx_done` sets `overrun`; the byte is dropped.
- `start` → WAIT_BYTE, with the same actions as from IDLE; `done` ← 0.

Rules:
- `start` while `busy` is ignored; there is no abort.
- `start` and `rx_done` in the same cycle in IDLE/DONE: `start` wins and the byte is not captured; `overrun` is not set.
- Addresses are written in raster order over rows 0..`end_reg[17:9]` and cols 0..`end_reg[8:0]`. Total writes = (end_row+1)·(end_col+1).
- `end_address` changes after start have no effect.
- Address arithmetic: the col counter never exceeds `end_col`. The row field never wraps within a load because the load terminates at `end_row`.
- Reset in any state: IDLE, address 0, `end_reg` 0, all outputs 0, immediately (asynchronous).

## Timing
- `rx_done` at cycle N (in WAIT_BYTE) → `mem_wen` = 1, `mem_data`/`mem_address` valid at cycle N+1. The next address appears at N+2.
- The earliest next capture is at cycle N+2. `rx_done` spacing ≥ 2 cycles is required; a pulse at N+1 is dropped with `overrun`.
- Last write at cycle M → `done` = 1 and `busy` = 0 from cycle M+1.
- `start` at cycle S → `busy` = 1, `done` = 0 from S+1. A byte is first acceptable at S+1.
- `mem_address` is stable whenever `mem_wen` is high. `mem_data` holds its last value when `mem_wen` is low.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-load (address 0x00005, `mem_wen` high) → all outputs 0 asynchronously; after release, `rx_done` pulses produce no writes until `start`.
- **2×3 load:** `end_address` = {9'd1, 9'd2}, `start`, then bytes 0x10..0x15 → writes at addresses 0x00000, 0x00001, 0x00002, 0x00200, 0x00201, 0x00202 with matching data. `done` rises the cycle after the sixth write.
- **Single location:** `end_address` = 0, one byte 0xA5 → one write of 0xA5 at address 0, then DONE. A further byte sets `overrun`, and no `mem_wen` occurs.
- **Back-to-back bytes:** `rx_done` pulses at N and N+1 → one write (byte N) and `overrun` = 1. Pulses at N and N+2 → two writes, `overrun` = 0.
- **Simultaneous events:** in DONE, pulse `start` and `rx_done` together → restart with `overrun` = 0 and `done` = 0, and no write that cycle. `start` pulsed mid-load → ignored, and address progression is unchanged.
- **Maximum range:** `end_address` = 0x3FFFF, spot-check the column wrap from 0x001FF to 0x00200 → the final write at 0x3FFFF, then `done`; no address wrap to 0.
